// File: rtl/cc_psr_branch_unit.sv
// Processor status register with a request/valid/ack branch-condition responder.
// Latches active-low ALU flags on committed CC-setting ops and keeps a sticky overflow trap.
module cc_psr_branch_unit #(
    parameter int unsigned DATAWIDTH_COND  = 4,
    parameter int unsigned DATAWIDTH_FLAGS = 4
) (
    input  logic                       CC_PSR_CLOCK_50,
    input  logic                       CC_PSR_RESET_InHigh,
    input  logic                       CC_PSR_negative_InLow,
    input  logic                       CC_PSR_zero_InLow,
    input  logic                       CC_PSR_overflow_InLow,
    input  logic                       CC_PSR_carry_InLow,
    input  logic                       CC_PSR_setCC_InLow,
    input  logic                       CC_PSR_commit_InHigh,
    input  logic                       CC_PSR_trapEnable_InHigh,
    input  logic                       CC_PSR_trapAck_InHigh,
    input  logic [DATAWIDTH_COND-1:0]  CC_PSR_cond_InBUS,
    input  logic                       CC_PSR_branchReq_InHigh,
    input  logic                       CC_PSR_branchAck_InHigh,
    output logic [DATAWIDTH_FLAGS-1:0] CC_PSR_flags_OutBUS,
    output logic                       CC_PSR_branchValid_OutHigh,
    output logic                       CC_PSR_branchTaken_OutHigh,
    output logic                       CC_PSR_busy_OutHigh,
    output logic                       CC_PSR_trap_OutHigh
);

    typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

    state_e                      state_q, state_d;
    logic [DATAWIDTH_FLAGS-1:0]  psr_q, psr_d;
    logic [DATAWIDTH_COND-1:0]   cond_q, cond_d;
    logic                        taken_q, taken_d;
    logic                        trap_q, trap_d;
    logic                        psr_update;

    // PSR bit order is {N,Z,V,C}.
    function automatic logic eval_cond(input logic [DATAWIDTH_COND-1:0]  cond,
                                       input logic [DATAWIDTH_FLAGS-1:0] f);
        logic res;
        res = 1'b0;
        case (cond)
            4'b0000: res = 1'b0;
            4'b1000: res = 1'b1;
            4'b0001: res = f[2];
            4'b1001: res = ~f[2];
            4'b0101: res = f[0];
            4'b1101: res = ~f[0];
            4'b0110: res = f[3];
            4'b1110: res = ~f[3];
            4'b0111: res = f[1];
            4'b1111: res = ~f[1];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    always_comb begin
        psr_update = CC_PSR_commit_InHigh & ~CC_PSR_setCC_InLow;
        psr_d      = psr_q;
        if (psr_update) begin
            psr_d = ~{CC_PSR_negative_InLow, CC_PSR_zero_InLow,
                      CC_PSR_overflow_InLow, CC_PSR_carry_InLow};
        end
    end

    // Set has priority over acknowledge.
    always_comb begin
        trap_d = trap_q;
        if (psr_update && CC_PSR_trapEnable_InHigh && psr_d[1]) begin
            trap_d = 1'b1;
        end else if (CC_PSR_trapAck_InHigh) begin
            trap_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cond_d  = cond_q;
        taken_d = taken_q;
        unique case (state_q)
            StIdle: begin
                if (CC_PSR_branchReq_InHigh) begin
                    cond_d  = CC_PSR_cond_InBUS;
                    state_d = StEval;
                end
            end
            StEval: begin
                // Forwarded PSR so a same-cycle commit is seen by this evaluation.
                taken_d = eval_cond(cond_q, psr_d);
                state_d = StResp;
            end
            StResp: begin
                if (CC_PSR_branchAck_InHigh) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CC_PSR_CLOCK_50 or posedge CC_PSR_RESET_InHigh) begin
        if (CC_PSR_RESET_InHigh) begin
            state_q <= StIdle;
            psr_q   <= '0;
            cond_q  <= '0;
            taken_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
            cond_q  <= cond_d;
            taken_q <= taken_d;
            trap_q  <= trap_d;
        end
    end

    assign CC_PSR_flags_OutBUS        = psr_q;
    assign CC_PSR_branchValid_OutHigh = (state_q == StResp);
    assign CC_PSR_branchTaken_OutHigh = taken_q;
    assign CC_PSR_busy_OutHigh        = (state_q != StIdle);
    assign CC_PSR_trap_OutHigh        = trap_q;

endmodule

// File: tb/tb_cc_psr_branch_unit.sv
// Self-checking bench for cc_psr_branch_unit: vector table for branch conditions,
// scoreboard queue for responses, and directed sequences for forwarding, trap and reset.
module tb_cc_psr_branch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       n_in, z_in, v_in, c_in;
    logic       setcc, commit, trap_en, trap_ack;
    logic [3:0] cond;
    logic       req, ack;
    logic [3:0] flags;
    logic       valid, taken, busy, trap;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    typedef struct {
        logic [3:0] psr;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    cc_psr_branch_unit #(
        .DATAWIDTH_COND (4),
        .DATAWIDTH_FLAGS(4)
    ) dut (
        .CC_PSR_CLOCK_50           (clk),
        .CC_PSR_RESET_InHigh       (rst),
        .CC_PSR_negative_InLow     (n_in),
        .CC_PSR_zero_InLow         (z_in),
        .CC_PSR_overflow_InLow     (v_in),
        .CC_PSR_carry_InLow        (c_in),
        .CC_PSR_setCC_InLow        (setcc),
        .CC_PSR_commit_InHigh      (commit),
        .CC_PSR_trapEnable_InHigh  (trap_en),
        .CC_PSR_trapAck_InHigh     (trap_ack),
        .CC_PSR_cond_InBUS         (cond),
        .CC_PSR_branchReq_InHigh   (req),
        .CC_PSR_branchAck_InHigh   (ack),
        .CC_PSR_flags_OutBUS       (flags),
        .CC_PSR_branchValid_OutHigh(valid),
        .CC_PSR_branchTaken_OutHigh(taken),
        .CC_PSR_busy_OutHigh       (busy),
        .CC_PSR_trap_OutHigh       (trap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Commit one CC-setting op that leaves PSR == f; called and returns at a negedge.
    task automatic load_psr(input logic [3:0] f);
        {n_in, z_in, v_in, c_in} = ~f;
        setcc  = 1'b0;
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        setcc  = 1'b1;
        {n_in, z_in, v_in, c_in} = 4'b1111;
        chk("psr_load", flags, f);
    endtask

    // Wait (bounded) for valid, then pop the scoreboard and compare taken.
    task automatic wait_resp(input string name, output int waited);
        logic e;
        waited = 0;
        while (!valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!valid) begin
            chk({name, "_timeout"}, 32'(valid), 32'd1);
        end else if (exp_q.size() == 0) begin
            chk({name, "_unexpected_resp"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(name, 32'(taken), 32'(e));
        end
    endtask

    task automatic run_branch(input logic [3:0] c, input logic e);
        int w;
        req  = 1'b1;
        cond = c;
        exp_q.push_back(e);
        @(negedge clk);
        req = 1'b0;
        chk("busy_eval", 32'(busy), 32'd1);
        wait_resp("taken", w);
        chk("latency", 32'(w), 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_after_ack", 32'({busy, valid}), 32'd0);
    endtask

    initial begin
        int w;
        rst = 1'b1;
        {n_in, z_in, v_in, c_in} = 4'b1111;
        setcc = 1'b1; commit = 1'b0; trap_en = 1'b0; trap_ack = 1'b0;
        cond = 4'b0000; req = 1'b0; ack = 1'b0;

        vecs = '{
            '{4'b0100, 4'b0001, 1'b1}, '{4'b0100, 4'b1001, 1'b0},
            '{4'b0100, 4'b0000, 1'b0}, '{4'b0100, 4'b1000, 1'b1},
            '{4'b0100, 4'b0011, 1'b0}, '{4'b0000, 4'b0001, 1'b0},
            '{4'b0000, 4'b1001, 1'b1}, '{4'b0000, 4'b0101, 1'b0},
            '{4'b0000, 4'b1101, 1'b1}, '{4'b0000, 4'b0110, 1'b0},
            '{4'b0000, 4'b1110, 1'b1}, '{4'b0000, 4'b0111, 1'b0},
            '{4'b0000, 4'b1111, 1'b1}, '{4'b1011, 4'b0101, 1'b1},
            '{4'b1011, 4'b1101, 1'b0}, '{4'b1011, 4'b0110, 1'b1},
            '{4'b1011, 4'b1110, 1'b0}, '{4'b1011, 4'b0111, 1'b1},
            '{4'b1011, 4'b1111, 1'b0}, '{4'b1011, 4'b0010, 1'b0},
            '{4'b1111, 4'b1010, 1'b0}, '{4'b1111, 4'b0100, 1'b0}
        };

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 32'({flags, valid, taken, busy, trap}), 32'd0);

        // Flag latch: InLow 0,1,1,0 -> PSR 1001; then setCC=1 or commit=0 must not update.
        {n_in, z_in, v_in, c_in} = 4'b0110;
        setcc = 1'b0; commit = 1'b1;
        @(negedge clk);
        chk("flag_latch", 32'(flags), 32'b1001);
        {n_in, z_in, v_in, c_in} = 4'b1001;
        setcc = 1'b1; commit = 1'b1;
        @(negedge clk);
        chk("hold_setcc_high", 32'(flags), 32'b1001);
        setcc = 1'b0; commit = 1'b0;
        @(negedge clk);
        chk("hold_no_commit", 32'(flags), 32'b1001);
        setcc = 1'b1; {n_in, z_in, v_in, c_in} = 4'b1111;

        foreach (vecs[i]) begin
            load_psr(vecs[i].psr);
            run_branch(vecs[i].cond, vecs[i].exp);
        end

        // Response held stable while ack is withheld.
        load_psr(4'b0100);
        req = 1'b1; cond = 4'b0001; exp_q.push_back(1'b1);
        @(negedge clk);
        req = 1'b0;
        wait_resp("taken_z", w);
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid_taken", 32'({valid, taken}), 32'b11);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_to_idle", 32'({valid, busy}), 32'd0);

        // Forwarding: commit during EVAL is seen.
        load_psr(4'b0000);
        req = 1'b1; cond = 4'b0001; exp_q.push_back(1'b1);
        @(negedge clk);
        req = 1'b0;
        z_in = 1'b0; setcc = 1'b0; commit = 1'b1;
        @(negedge clk);
        z_in = 1'b1; setcc = 1'b1; commit = 1'b0;
        wait_resp("fwd_eval", w);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Commit during RESP leaves registered taken unchanged.
        load_psr(4'b0000);
        req = 1'b1; cond = 4'b0001; exp_q.push_back(1'b0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        z_in = 1'b0; setcc = 1'b0; commit = 1'b1;
        @(negedge clk);
        z_in = 1'b1; setcc = 1'b1; commit = 1'b0;
        wait_resp("no_fwd_resp", w);
        chk("flags_after_resp_commit", 32'(flags), 32'b0100);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Requests while busy are ignored; no second response.
        load_psr(4'b0000);
        req = 1'b1; cond = 4'b0001; exp_q.push_back(1'b0);
        @(negedge clk);
        cond = 4'b1000;
        @(negedge clk);
        wait_resp("ignored_req_orig", w);
        @(negedge clk);
        chk("ignored_req_stable", 32'({valid, taken}), 32'b10);
        req = 1'b0; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_second_resp", 32'({valid, busy}), 32'd0);
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // Trap: set, set-wins-over-ack, ack alone clears, disabled never sets.
        trap_en = 1'b1;
        v_in = 1'b0; setcc = 1'b0; commit = 1'b1;
        @(negedge clk);
        chk("trap_set", 32'(trap), 32'd1);
        trap_ack = 1'b1;
        @(negedge clk);
        chk("trap_set_wins", 32'(trap), 32'd1);
        commit = 1'b0; setcc = 1'b1; v_in = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        chk("trap_ack_clears", 32'(trap), 32'd0);
        trap_en = 1'b0;
        v_in = 1'b0; setcc = 1'b0; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0; setcc = 1'b1; v_in = 1'b1;
        chk("trap_disabled", 32'({trap, flags[1]}), 32'b01);
        trap_en = 1'b1;
        load_psr(4'b0010);
        trap_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("trap_sticky", 32'(trap), 32'd1);

        // Reset in RESP aborts the transaction asynchronously.
        req = 1'b1; cond = 4'b1000;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("in_resp", 32'(valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk("async_reset", 32'({flags, valid, taken, busy, trap}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("no_resp_after_reset", 32'({valid, busy}), 32'd0);
        end

        // Back-to-back requests still work after reset.
        load_psr(4'b0001);
        run_branch(4'b0101, 1'b1);
        run_branch(4'b1101, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
